// File: rtl/attack_arbiter.sv
// attack_arbiter: round-robin front end sharing one attack evaluator between two requesters.
// Define ATTACK_ARBITER_TIMEOUT_EN to bound the WAIT state to TIMEOUT_CYCLES cycles.
`ifndef PIECE_BITS
`define PIECE_BITS 4
`endif

module attack_arbiter #(
  parameter int PIECE_WIDTH    = `PIECE_BITS,
  parameter int SIDE_WIDTH     = PIECE_WIDTH*8,
  parameter int BOARD_WIDTH    = PIECE_WIDTH*64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_0,
  input  logic                   req_1,
  input  logic [BOARD_WIDTH-1:0] board_0,
  input  logic [BOARD_WIDTH-1:0] board_1,
  input  logic                   white_to_move_0,
  input  logic                   white_to_move_1,
  output logic                   done_0,
  output logic                   done_1,
  output logic [63:0]            white_is_attacking,
  output logic [63:0]            black_is_attacking,
  output logic                   timeout,
  output logic                   busy,
  output logic [BOARD_WIDTH-1:0] eval_board,
  output logic                   eval_board_valid,
  output logic                   eval_white_to_move,
  input  logic                   eval_done,
  input  logic [63:0]            eval_white_is_attacking,
  input  logic [63:0]            eval_black_is_attacking
);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESPOND
  } state_t;

  state_t state;
  logic   pend_0;
  logic   pend_1;
  logic   last_served;
  logic   grant;
  logic   acc_0;
  logic   acc_1;
  logic   want_0;
  logic   want_1;
  logic   pick;
  logic   sel_wtm;
  logic [BOARD_WIDTH-1:0] sel_board;

`ifdef ATTACK_ARBITER_TIMEOUT_EN
  localparam int CNT_W =
    ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  logic [CNT_W-1:0] cnt;
`endif

  // strobes are dropped when already pending or from the requester in service
  assign acc_0 = req_0 & ~pend_0 & ~((state != IDLE) & ~grant);
  assign acc_1 = req_1 & ~pend_1 & ~((state != IDLE) & grant);
  assign want_0 = pend_0 | acc_0;
  assign want_1 = pend_1 | acc_1;
  assign pick = want_1 & (~want_0 | ~last_served);
  assign sel_board = pick ? board_1 : board_0;
  assign sel_wtm = pick ? white_to_move_1 : white_to_move_0;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pend_0 <= 1'b0;
      pend_1 <= 1'b0;
      last_served <= 1'b1;
      grant <= 1'b0;
      done_0 <= 1'b0;
      done_1 <= 1'b0;
      white_is_attacking <= '0;
      black_is_attacking <= '0;
      eval_board <= '0;
      eval_board_valid <= 1'b0;
      eval_white_to_move <= 1'b0;
`ifdef ATTACK_ARBITER_TIMEOUT_EN
      timeout <= 1'b0;
      cnt <= '0;
`endif
    end else begin
      done_0 <= 1'b0;
      done_1 <= 1'b0;
      eval_board_valid <= 1'b0;
      pend_0 <= want_0;
      pend_1 <= want_1;
`ifdef ATTACK_ARBITER_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (want_0 | want_1) begin
            grant <= pick;
            if (pick) pend_1 <= 1'b0;
            else pend_0 <= 1'b0;
            for (int r = 0; r < 8; r++) begin
              eval_board[r*SIDE_WIDTH +: SIDE_WIDTH]
                <= sel_board[r*SIDE_WIDTH +: SIDE_WIDTH];
            end
            eval_white_to_move <= sel_wtm;
            eval_board_valid <= 1'b1;
            state <= LAUNCH;
          end
        end
        LAUNCH: begin
          state <= WAIT;
`ifdef ATTACK_ARBITER_TIMEOUT_EN
          cnt <= '0;
`endif
        end
        WAIT: begin
`ifdef ATTACK_ARBITER_TIMEOUT_EN
          cnt <= cnt + CNT_W'(1);
`endif
          if (eval_done) begin
            white_is_attacking <= eval_white_is_attacking;
            black_is_attacking <= eval_black_is_attacking;
            done_0 <= ~grant;
            done_1 <= grant;
            state <= RESPOND;
          end
`ifdef ATTACK_ARBITER_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYCLES-1)) begin
            white_is_attacking <= '0;
            black_is_attacking <= '0;
            timeout <= 1'b1;
            done_0 <= ~grant;
            done_1 <= grant;
            state <= RESPOND;
          end
`endif
        end
        RESPOND: begin
          last_served <= grant;
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef ATTACK_ARBITER_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_attack_arbiter.sv
// tb_attack_arbiter: directed scenarios for attack_arbiter.
// Timeout scenarios run only when ATTACK_ARBITER_TIMEOUT_EN is defined.
module tb_attack_arbiter;

  localparam int PW = 4;
  localparam int BW = PW*64;
  localparam int TO = 16;

  localparam logic [BW-1:0] BOARD_A =
    (BW'(4'h1) << (35*4)) | (BW'(4'h1) << (28*4)) |
    (BW'(4'hC) << (36*4));
  localparam logic [BW-1:0] BOARD_B = {64{4'h3}};
  localparam logic [BW-1:0] BOARD_C = {32{8'hA5}};
  localparam logic [63:0] WA =
    (64'd1 << 35) | (64'd1 << 37) | (64'd1 << 42) | (64'd1 << 44);
  localparam logic [63:0] BA =
    (64'd1 << 28) | (64'd1 << 35) | (64'd1 << 37) | (64'd1 << 38) |
    (64'd1 << 39) | (64'd1 << 44) | (64'd1 << 52) | (64'd1 << 60);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_0 = 1'b0;
  logic req_1 = 1'b0;
  logic [BW-1:0] board_0 = '0;
  logic [BW-1:0] board_1 = '0;
  logic white_to_move_0 = 1'b0;
  logic white_to_move_1 = 1'b0;
  logic done_0;
  logic done_1;
  logic [63:0] white_is_attacking;
  logic [63:0] black_is_attacking;
  logic timeout;
  logic busy;
  logic [BW-1:0] eval_board;
  logic eval_board_valid;
  logic eval_white_to_move;
  logic eval_done = 1'b0;
  logic [63:0] eval_white_is_attacking = '0;
  logic [63:0] eval_black_is_attacking = '0;

  int checks = 0;
  int failures = 0;
  int n_done0 = 0;
  int n_done1 = 0;
  int n_valid = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done_0 === 1'b1) n_done0++;
    if (done_1 === 1'b1) n_done1++;
    if (eval_board_valid === 1'b1) n_valid++;
  end

  attack_arbiter #(
    .PIECE_WIDTH(PW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_0(req_0),
    .req_1(req_1),
    .board_0(board_0),
    .board_1(board_1),
    .white_to_move_0(white_to_move_0),
    .white_to_move_1(white_to_move_1),
    .done_0(done_0),
    .done_1(done_1),
    .white_is_attacking(white_is_attacking),
    .black_is_attacking(black_is_attacking),
    .timeout(timeout),
    .busy(busy),
    .eval_board(eval_board),
    .eval_board_valid(eval_board_valid),
    .eval_white_to_move(eval_white_to_move),
    .eval_done(eval_done),
    .eval_white_is_attacking(eval_white_is_attacking),
    .eval_black_is_attacking(eval_black_is_attacking)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic finish_eval(input logic [63:0] w, input logic [63:0] b);
    eval_white_is_attacking = w;
    eval_black_is_attacking = b;
    eval_done = 1'b1;
    tick(1);
    eval_done = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({busy, done_0, done_1, timeout, eval_board_valid,
         eval_white_to_move} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000",
        {busy, done_0, done_1, timeout, eval_board_valid,
         eval_white_to_move});
    end
    checks++;
    if (eval_board !== '0) begin
      failures++;
      $display("FAIL reset_board got=%h exp=0", eval_board);
    end
    checks++;
    if ({white_is_attacking, black_is_attacking} !== 128'b0) begin
      failures++;
      $display("FAIL reset_vec got=%h/%h exp=0",
        white_is_attacking, black_is_attacking);
    end
  endtask

  task automatic test_single;
    int v0, d0, d1;
    v0 = n_valid; d0 = n_done0; d1 = n_done1;
    tick(9);
    board_0 = BOARD_A;
    white_to_move_0 = 1'b1;
    req_0 = 1'b1;
    tick(1);
    req_0 = 1'b0;
    checks++;
    if ({eval_board_valid, busy, eval_white_to_move} !== 3'b111) begin
      failures++;
      $display("FAIL single_launch got=%b exp=111",
        {eval_board_valid, busy, eval_white_to_move});
    end
    checks++;
    if (eval_board !== BOARD_A) begin
      failures++;
      $display("FAIL single_board got=%h exp=%h", eval_board, BOARD_A);
    end
    tick(1);
    checks++;
    if ({eval_board_valid, busy} !== 2'b01) begin
      failures++;
      $display("FAIL single_wait got=%b exp=01",
        {eval_board_valid, busy});
    end
    tick(8);
    finish_eval(WA, BA);
    checks++;
    if ({done_0, done_1, timeout} !== 3'b100) begin
      failures++;
      $display("FAIL single_done got=%b exp=100",
        {done_0, done_1, timeout});
    end
    checks++;
    if (white_is_attacking !== WA || black_is_attacking !== BA) begin
      failures++;
      $display("FAIL single_vec got=%h/%h exp=%h/%h",
        white_is_attacking, black_is_attacking, WA, BA);
    end
    tick(1);
    checks++;
    if ({done_0, busy} !== 2'b00) begin
      failures++;
      $display("FAIL single_idle got=%b exp=00", {done_0, busy});
    end
    tick(3);
    checks++;
    if (n_valid - v0 != 1 || n_done0 - d0 != 1 || n_done1 - d1 != 0) begin
      failures++;
      $display("FAIL single_counts got=%0d/%0d/%0d exp=1/1/0",
        n_valid - v0, n_done0 - d0, n_done1 - d1);
    end
  endtask

  task automatic test_tie;
    do_reset();
    board_0 = BOARD_A;
    board_1 = BOARD_B;
    white_to_move_0 = 1'b1;
    white_to_move_1 = 1'b0;
    req_0 = 1'b1;
    req_1 = 1'b1;
    tick(1);
    req_0 = 1'b0;
    req_1 = 1'b0;
    checks++;
    if (eval_board_valid !== 1'b1 || eval_board !== BOARD_A) begin
      failures++;
      $display("FAIL tie_first got=%b/%h exp=1/%h",
        eval_board_valid, eval_board, BOARD_A);
    end
    tick(3);
    finish_eval(64'h1, 64'h2);
    checks++;
    if ({done_0, done_1} !== 2'b10) begin
      failures++;
      $display("FAIL tie_done0 got=%b exp=10", {done_0, done_1});
    end
    tick(1);
    checks++;
    if ({eval_board_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL tie_gap got=%b exp=00", {eval_board_valid, busy});
    end
    tick(1);
    checks++;
    if (eval_board_valid !== 1'b1 || eval_board !== BOARD_B ||
        eval_white_to_move !== 1'b0) begin
      failures++;
      $display("FAIL tie_second got=%b/%b/%h exp=1/0/%h",
        eval_board_valid, eval_white_to_move, eval_board, BOARD_B);
    end
    tick(2);
    finish_eval(64'h3, 64'h4);
    checks++;
    if ({done_0, done_1} !== 2'b01 || white_is_attacking !== 64'h3) begin
      failures++;
      $display("FAIL tie_done1 got=%b/%h exp=01/3",
        {done_0, done_1}, white_is_attacking);
    end
    tick(2);
  endtask

  task automatic test_queued;
    board_0 = BOARD_B;
    board_1 = BOARD_C;
    white_to_move_1 = 1'b1;
    req_0 = 1'b1;
    tick(1);
    req_0 = 1'b0;
    tick(2);
    req_1 = 1'b1;
    tick(1);
    req_1 = 1'b0;
    checks++;
    if (eval_board !== BOARD_B || busy !== 1'b1) begin
      failures++;
      $display("FAIL queued_hold got=%h/%b exp=%h/1",
        eval_board, busy, BOARD_B);
    end
    tick(2);
    finish_eval(64'h10, 64'h20);
    checks++;
    if ({done_0, done_1} !== 2'b10) begin
      failures++;
      $display("FAIL queued_done0 got=%b exp=10", {done_0, done_1});
    end
    tick(2);
    checks++;
    if (eval_board_valid !== 1'b1 || eval_board !== BOARD_C ||
        eval_white_to_move !== 1'b1) begin
      failures++;
      $display("FAIL queued_launch1 got=%b/%h exp=1/%h",
        eval_board_valid, eval_board, BOARD_C);
    end
    tick(1);
    finish_eval(64'h30, 64'h40);
    checks++;
    if ({done_0, done_1} !== 2'b01) begin
      failures++;
      $display("FAIL queued_done1 got=%b exp=01", {done_0, done_1});
    end
    tick(2);
  endtask

  task automatic test_fairness;
    board_0 = BOARD_A;
    board_1 = BOARD_B;
    req_0 = 1'b1;
    tick(1);
    req_0 = 1'b0;
    tick(2);
    finish_eval(64'h5, 64'h6);
    tick(2);
    req_0 = 1'b1;
    req_1 = 1'b1;
    tick(1);
    req_0 = 1'b0;
    req_1 = 1'b0;
    checks++;
    if (eval_board !== BOARD_B) begin
      failures++;
      $display("FAIL fair_pick1 got=%h exp=%h", eval_board, BOARD_B);
    end
    tick(2);
    finish_eval(64'h7, 64'h8);
    checks++;
    if ({done_0, done_1} !== 2'b01) begin
      failures++;
      $display("FAIL fair_done1 got=%b exp=01", {done_0, done_1});
    end
    tick(2);
    checks++;
    if (eval_board_valid !== 1'b1 || eval_board !== BOARD_A) begin
      failures++;
      $display("FAIL fair_then0 got=%b/%h exp=1/%h",
        eval_board_valid, eval_board, BOARD_A);
    end
    tick(1);
    finish_eval(64'h9, 64'hA);
    tick(2);
  endtask

  task automatic test_duplicate;
    int v0, d0, d1;
    v0 = n_valid; d0 = n_done0; d1 = n_done1;
    board_1 = BOARD_C;
    req_1 = 1'b1;
    tick(1);
    req_1 = 1'b0;
    req_0 = 1'b1;
    tick(1);
    req_1 = 1'b1;
    tick(1);
    req_0 = 1'b0;
    req_1 = 1'b0;
    tick(2);
    finish_eval(64'hB, 64'hC);
    tick(3);
    finish_eval(WA, BA);
    tick(6);
    checks++;
    if (n_valid - v0 != 2) begin
      failures++;
      $display("FAIL dup_launches got=%0d exp=2", n_valid - v0);
    end
    checks++;
    if (n_done0 - d0 != 1 || n_done1 - d1 != 1) begin
      failures++;
      $display("FAIL dup_dones got=%0d/%0d exp=1/1",
        n_done0 - d0, n_done1 - d1);
    end
  endtask

  task automatic test_reset_mid;
    int v0, d0, d1;
    req_0 = 1'b1;
    tick(1);
    req_0 = 1'b0;
    tick(1);
    req_1 = 1'b1;
    tick(1);
    req_1 = 1'b0;
    v0 = n_valid; d0 = n_done0; d1 = n_done1;
    do_reset();
    checks++;
    if ({busy, done_0, done_1, eval_board_valid} !== 4'b0 ||
        eval_board !== '0 || white_is_attacking !== '0) begin
      failures++;
      $display("FAIL midreset_clear got=%b/%h exp=0/0",
        {busy, done_0, done_1, eval_board_valid}, eval_board);
    end
    tick(2);
    finish_eval(64'hFF, 64'hFF);
    tick(5);
    checks++;
    if (busy !== 1'b0 || black_is_attacking !== '0 ||
        white_is_attacking !== '0) begin
      failures++;
      $display("FAIL midreset_idle got=%b/%h exp=0/0",
        busy, white_is_attacking);
    end
    checks++;
    if (n_valid != v0 || n_done0 != d0 || n_done1 != d1) begin
      failures++;
      $display("FAIL midreset_pulses got=%0d/%0d/%0d exp=0/0/0",
        n_valid - v0, n_done0 - d0, n_done1 - d1);
    end
  endtask

`ifdef ATTACK_ARBITER_TIMEOUT_EN
  task automatic test_timeout;
    req_0 = 1'b1;
    tick(1);
    req_0 = 1'b0;
    finish_eval(64'h0, 64'h0);
    req_0 = 1'b1;
    tick(1);
    req_0 = 1'b0;
    tick(2);
    finish_eval(WA, BA);
    tick(2);
    req_0 = 1'b1;
    tick(1);
    req_0 = 1'b0;
    tick(16);
    checks++;
    if ({done_0, busy} !== 2'b01) begin
      failures++;
      $display("FAIL to_early got=%b exp=01", {done_0, busy});
    end
    tick(1);
    checks++;
    if ({done_0, timeout} !== 2'b11 || white_is_attacking !== '0 ||
        black_is_attacking !== '0) begin
      failures++;
      $display("FAIL to_expire got=%b/%h/%h exp=11/0/0",
        {done_0, timeout}, white_is_attacking, black_is_attacking);
    end
    tick(1);
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL to_pulse got=%b exp=0", timeout);
    end
    tick(1);
    req_0 = 1'b1;
    tick(1);
    req_0 = 1'b0;
    tick(16);
    finish_eval(WA, BA);
    checks++;
    if ({done_0, timeout} !== 2'b10 || white_is_attacking !== WA) begin
      failures++;
      $display("FAIL to_race got=%b/%h exp=10/%h",
        {done_0, timeout}, white_is_attacking, WA);
    end
    tick(2);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_queued();
    test_fairness();
    test_duplicate();
    test_reset_mid();
`ifdef ATTACK_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
